// File: rtl/hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_v2
//  Description : Hazard and forwarding controller for a 5-stage RISC-V
//                pipeline. Generates EX operand forwarding selects,
//                counted load-use stalls, multi-cycle EX stall handshake,
//                branch-redirect flushes and a saturating stall counter.
//  Revision    : 2.0 - counted load latency, EX wait, branch flush
// ============================================================================
module hazard_ctrl_v2 #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic [AW-1:0]    rd_e,
  input  logic [AW-1:0]    rd_m,
  input  logic [AW-1:0]    rd_w,
  input  logic             mem_read_e,
  input  logic [AW-1:0]    rs1_d,
  input  logic [AW-1:0]    rs2_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic [AW-1:0]    rs1_e,
  input  logic [AW-1:0]    rs2_e,
  input  logic             branch_taken_e,
  input  logic             ex_start,
  input  logic             ex_done,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0]       c_run        = 2'b00;
  localparam logic [1:0]       c_load_stall = 2'b01;
  localparam logic [1:0]       c_ex_wait    = 2'b10;
  localparam logic [1:0]       c_fwd_rf     = 2'b00;
  localparam logic [1:0]       c_fwd_mem    = 2'b10;
  localparam logic [1:0]       c_fwd_wb     = 2'b01;
  localparam logic [2:0]       c_lcnt_init  = 3'(LOAD_LAT - 1);
  localparam logic [2:0]       c_lcnt_one   = 3'd1;
  localparam logic [AW-1:0]    c_reg_zero   = '0;
  localparam logic [CNT_W-1:0] c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [2:0]       lcnt_q, lcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;
  logic             mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

  // Load in EX whose destination is actually read by the ID instruction
  assign lu = mem_read_e && (rd_e != c_reg_zero) &&
              ((use_rs1_d && (rd_e == rs1_d)) || (use_rs2_d && (rd_e == rs2_d)));

  assign mem_hit_a = reg_write_m && (rd_m != c_reg_zero) && (rd_m == rs1_e);
  assign mem_hit_b = reg_write_m && (rd_m != c_reg_zero) && (rd_m == rs2_e);
  assign wb_hit_a  = reg_write_w && (rd_w != c_reg_zero) && (rd_w == rs1_e);
  assign wb_hit_b  = reg_write_w && (rd_w != c_reg_zero) && (rd_w == rs2_e);

  // Forwarding selects: MEM result is younger, so it wins over WB
  always_comb begin
    forward_a_e = c_fwd_rf;
    forward_b_e = c_fwd_rf;
    if (!rst) begin
      if (mem_hit_a)     forward_a_e = c_fwd_mem;
      else if (wb_hit_a) forward_a_e = c_fwd_wb;
      if (mem_hit_b)     forward_b_e = c_fwd_mem;
      else if (wb_hit_b) forward_b_e = c_fwd_wb;
    end
  end

  // State, bubble counter and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_run;
      lcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state: mul/div wait beats branch, branch beats load-use
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      c_run: begin
        lcnt_d = 3'd0;
        if (ex_start && !ex_done) begin
          state_d = c_ex_wait;
        end else if (branch_taken_e) begin
          state_d = c_run;
        end else if (lu && (LOAD_LAT > 1)) begin
          state_d = c_load_stall;
          lcnt_d  = c_lcnt_init;
        end
      end
      c_load_stall: begin
        lcnt_d = lcnt_q - c_lcnt_one;
        if (lcnt_q == c_lcnt_one) state_d = c_run;
      end
      c_ex_wait: begin
        if (ex_done) state_d = c_run;
      end
      default: begin
        state_d = c_run;
        lcnt_d  = 3'd0;
      end
    endcase
  end

  // Output decode: stalls and flushes for the current state and inputs
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (!rst) begin
      case (state_q)
        c_run: begin
          if (ex_start && !ex_done) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
          end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        c_load_stall: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        c_ex_wait: begin
          if (!ex_done) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
          end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        default: begin
          stall_f = 1'b0;
        end
      endcase
    end
  end

  // Saturating count of fetch-stall cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + c_cnt_one;
  end

  assign state_o   = rst ? c_run : state_q;
  assign stall_cnt = rst ? '0 : stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_v2
//  Description : Self-checking bench for hazard_ctrl_v2 (LOAD_LAT=3, CNT_W=4):
//                vector table, directed multi-cycle sequences and random
//                stimulus against a behavioural model.
//  Revision    : 1.0
// ============================================================================
module tb_hazard_ctrl_v2;

  localparam int AW       = 5;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;

  typedef struct {
    logic          rst, rwm, rww, mre, u1, u2, br, xs, xd;
    logic [AW-1:0] rd_e, rd_m, rd_w, rs1_d, rs2_d, rs1_e, rs2_e;
  } in_t;

  // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
  typedef struct {
    in_t      i;
    logic [1:0] fa, fb;
    logic [5:0] ctl;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst, reg_write_m, reg_write_w, mem_read_e;
  logic [AW-1:0]    rd_e, rd_m, rd_w, rs1_d, rs2_d, rs1_e, rs2_e;
  logic             use_rs1_d, use_rs2_d, branch_taken_e, ex_start, ex_done;
  logic [1:0]       forward_a_e, forward_b_e, state_o;
  logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int m_bub  = 0;   // load bubbles still owed after the detection cycle
  bit m_busy = 0;   // a mul/div op is occupying EX
  int m_cnt  = 0;   // stall cycles seen, saturating

  logic [1:0] e_fa, e_fb;
  logic [5:0] e_ctl;

  always #5 clk = ~clk;

  hazard_ctrl_v2 #(.AW(AW), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .mem_read_e(mem_read_e),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e),
    .branch_taken_e(branch_taken_e), .ex_start(ex_start), .ex_done(ex_done),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .state_o(state_o), .stall_cnt(stall_cnt)
  );

  function automatic in_t idle();
    in_t v;
    v.rst = 0; v.rwm = 0; v.rww = 0; v.mre = 0; v.u1 = 0; v.u2 = 0;
    v.br = 0; v.xs = 0; v.xd = 0;
    v.rd_e = 0; v.rd_m = 0; v.rd_w = 0; v.rs1_d = 0; v.rs2_d = 0;
    v.rs1_e = 0; v.rs2_e = 0;
    return v;
  endfunction

  function automatic logic [1:0] fwd(input in_t v, input logic [AW-1:0] rs);
    if (v.rwm && v.rd_m != 0 && v.rd_m == rs) return 2'b10;
    if (v.rww && v.rd_w != 0 && v.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model one cycle: expected combinational outputs now, state after edge.
  task automatic model(input in_t v);
    bit lu;
    bit sf, sd, se, fd, fe, fm;
    lu = v.mre && v.rd_e != 0 &&
         ((v.u1 && v.rd_e == v.rs1_d) || (v.u2 && v.rd_e == v.rs2_d));
    {sf, sd, se, fd, fe, fm} = 6'b0;
    e_fa = v.rst ? 2'b00 : fwd(v, v.rs1_e);
    e_fb = v.rst ? 2'b00 : fwd(v, v.rs2_e);
    if (v.rst) begin
      m_bub = 0; m_busy = 0; m_cnt = 0;
    end else begin
      if (m_bub > 0) begin
        sf = 1; sd = 1; fe = 1;
        m_bub--;
      end else if (m_busy) begin
        if (!v.xd) begin
          sf = 1; sd = 1; se = 1; fm = 1;
        end else begin
          m_busy = 0;
          if (v.br) begin fd = 1; fe = 1; end
        end
      end else if (v.xs && !v.xd) begin
        sf = 1; sd = 1; se = 1; fm = 1;
        m_busy = 1;
      end else if (v.br) begin
        fd = 1; fe = 1;
      end else if (lu) begin
        sf = 1; sd = 1; fe = 1;
        m_bub = LOAD_LAT - 1;
      end
      if (sf && m_cnt < CNT_MAX) m_cnt++;
    end
    e_ctl = {sf, sd, se, fd, fe, fm};
  endtask

  // Called 1ns after a rising edge; drives, checks comb outputs at the
  // falling edge, then checks registered outputs 1ns after the next edge.
  task automatic step(input in_t v);
    logic [5:0] ctl;
    int         e_state;
    rst = v.rst; reg_write_m = v.rwm; reg_write_w = v.rww; mem_read_e = v.mre;
    rd_e = v.rd_e; rd_m = v.rd_m; rd_w = v.rd_w;
    rs1_d = v.rs1_d; rs2_d = v.rs2_d; use_rs1_d = v.u1; use_rs2_d = v.u2;
    rs1_e = v.rs1_e; rs2_e = v.rs2_e;
    branch_taken_e = v.br; ex_start = v.xs; ex_done = v.xd;
    @(negedge clk);
    model(v);
    ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m};
    check("forward_a_e", 32'(forward_a_e), 32'(e_fa));
    check("forward_b_e", 32'(forward_b_e), 32'(e_fb));
    check("stall_flush", 32'(ctl), 32'(e_ctl));
    @(posedge clk);
    #1;
    e_state = (m_bub > 0) ? 1 : (m_busy ? 2 : 0);
    check("state_o", 32'(state_o), 32'(e_state));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    in_t v;
    v = idle(); v.rst = 1;
    step(v);
  endtask

  vec_t tbl[10];

  initial begin
    in_t v;
    logic [5:0] ctl;

    // ---------------- vector table (all rows leave the FSM in RUN) -------
    v = idle(); v.rwm = 1; v.rd_m = 5; v.rs1_e = 5;
    tbl[0] = '{v, 2'b10, 2'b00, 6'b000000};
    v.rww = 1; v.rd_w = 5; v.rs2_e = 5;
    tbl[1] = '{v, 2'b10, 2'b10, 6'b000000};
    v.rd_m = 0;
    tbl[2] = '{v, 2'b01, 2'b01, 6'b000000};
    v = idle(); v.rwm = 1; v.rd_m = 6; v.rww = 1; v.rd_w = 5; v.rs1_e = 6; v.rs2_e = 5;
    tbl[3] = '{v, 2'b10, 2'b01, 6'b000000};
    v = idle(); v.rww = 1; v.rd_w = 0; v.rs1_e = 0; v.rwm = 0; v.rd_m = 3; v.rs2_e = 3;
    tbl[4] = '{v, 2'b00, 2'b00, 6'b000000};
    v = idle(); v.rst = 1; v.rwm = 1; v.rd_m = 4; v.rs1_e = 4; v.rs2_e = 4;
    v.mre = 1; v.rd_e = 7; v.rs2_d = 7; v.u2 = 1; v.br = 1; v.xs = 1;
    tbl[5] = '{v, 2'b00, 2'b00, 6'b000000};
    v = idle(); v.br = 1; v.mre = 1; v.rd_e = 7; v.rs2_d = 7; v.u2 = 1;
    tbl[6] = '{v, 2'b00, 2'b00, 6'b000110};
    v = idle(); v.mre = 1; v.rd_e = 0; v.rs1_d = 0; v.u1 = 1;
    tbl[7] = '{v, 2'b00, 2'b00, 6'b000000};
    v = idle(); v.xs = 1; v.xd = 1;
    tbl[8] = '{v, 2'b00, 2'b00, 6'b000000};
    v.br = 1;
    tbl[9] = '{v, 2'b00, 2'b00, 6'b000110};

    rst = 1; reg_write_m = 0; reg_write_w = 0; mem_read_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    use_rs1_d = 0; use_rs2_d = 0; branch_taken_e = 0; ex_start = 0; ex_done = 0;
    @(posedge clk); #1;

    do_reset();
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_cnt", 32'(stall_cnt), 32'd0);

    for (int k = 0; k < 10; k++) begin
      rst = tbl[k].i.rst; reg_write_m = tbl[k].i.rwm; reg_write_w = tbl[k].i.rww;
      mem_read_e = tbl[k].i.mre; rd_e = tbl[k].i.rd_e; rd_m = tbl[k].i.rd_m;
      rd_w = tbl[k].i.rd_w; rs1_d = tbl[k].i.rs1_d; rs2_d = tbl[k].i.rs2_d;
      use_rs1_d = tbl[k].i.u1; use_rs2_d = tbl[k].i.u2;
      rs1_e = tbl[k].i.rs1_e; rs2_e = tbl[k].i.rs2_e;
      branch_taken_e = tbl[k].i.br; ex_start = tbl[k].i.xs; ex_done = tbl[k].i.xd;
      @(negedge clk);
      ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m};
      check("tbl_fa", 32'(forward_a_e), 32'(tbl[k].fa));
      check("tbl_fb", 32'(forward_b_e), 32'(tbl[k].fb));
      check("tbl_ctl", 32'(ctl), 32'(tbl[k].ctl));
      @(posedge clk); #1;
      check("tbl_state", 32'(state_o), 32'd0);
    end
    m_bub = 0; m_busy = 0; m_cnt = 0;

    // ---------------- load-use, LOAD_LAT=3 ----------------
    do_reset();
    v = idle(); v.mre = 1; v.rd_e = 7; v.rs2_d = 7; v.u2 = 1;
    step(v);
    check("lu_c0_ctl", 32'(e_ctl), 32'b110010);
    check("lu_c0_state", 32'(state_o), 32'd1);
    step(idle());
    check("lu_c1_state", 32'(state_o), 32'd1);
    step(idle());
    check("lu_c2_state", 32'(state_o), 32'd0);
    check("lu_cnt", 32'(stall_cnt), 32'd3);
    v.u2 = 0;
    step(v);
    check("lu_nouse_cnt", 32'(stall_cnt), 32'd3);

    // ---------------- multi-cycle EX with branch during wait -------------
    do_reset();
    v = idle(); v.xs = 1;
    step(v);
    step(v);
    v.br = 1; step(v);
    check("exw_br_ignored", 32'({stall_f, flush_d}), 32'b10);
    v.br = 0; step(v);
    check("exw_state", 32'(state_o), 32'd2);
    v.xd = 1; v.br = 1; step(v);
    check("exw_done_state", 32'(state_o), 32'd0);
    check("exw_cnt", 32'(stall_cnt), 32'd4);
    step(idle());

    // ---------------- reset during load stall ----------------
    v = idle(); v.mre = 1; v.rd_e = 9; v.rs1_d = 9; v.u1 = 1;
    step(v);
    v = idle(); v.rst = 1; step(v);
    check("rst_mid_state", 32'(state_o), 32'd0);
    check("rst_mid_cnt", 32'(stall_cnt), 32'd0);
    step(idle());

    // ---------------- counter saturation ----------------
    v = idle(); v.xs = 1;
    for (int k = 0; k < 20; k++) step(v);
    check("sat_cnt", 32'(stall_cnt), 32'd15);
    v.xd = 1; step(v);
    step(idle());

    // ---------------- random ----------------
    for (int k = 0; k < 400; k++) begin
      v = idle();
      v.rst   = ($urandom_range(0, 39) == 0);
      v.rwm   = 1'($urandom); v.rww = 1'($urandom);
      v.rd_e  = AW'($urandom_range(0, 3)); v.rd_m = AW'($urandom_range(0, 3));
      v.rd_w  = AW'($urandom_range(0, 3));
      v.rs1_d = AW'($urandom_range(0, 3)); v.rs2_d = AW'($urandom_range(0, 3));
      v.rs1_e = AW'($urandom_range(0, 3)); v.rs2_e = AW'($urandom_range(0, 3));
      v.mre   = ($urandom_range(0, 2) == 0);
      v.u1    = 1'($urandom); v.u2 = 1'($urandom);
      v.br    = ($urandom_range(0, 5) == 0);
      v.xs    = ($urandom_range(0, 7) == 0);
      v.xd    = ($urandom_range(0, 3) == 0);
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
